// File: rtl/regfile_pkg.sv
// Shared types and constants for the parameterised register file.
package regfile_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Bits needed to address n entries; evaluated at elaboration.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux, range/zero masking and, when
// REGFILE_PARAM_BYPASS_EN is defined, write-through forwarding.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int AW       = clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic                        ready,
  input  logic [AW-1:0]               addr,
  input  logic                        wr_fwd,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            data
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic in_range;
  logic is_zero;
  logic hit;

  assign in_range = {1'b0, addr} < DEPTH_W;
  assign is_zero  = (ZERO_REG != 0) && (addr == '0);

`ifdef REGFILE_PARAM_BYPASS_EN
  // wr_fwd is only high for a write that will really land this edge.
  assign hit = wr_fwd && (wr_addr == addr);
`else
  logic unused_fwd;
  assign unused_fwd = ^{wr_fwd, wr_addr, wr_data};
  assign hit        = 1'b0;
`endif

  // Range and zero-register masking take precedence over forwarding.
  always_comb begin
    data = '0;
    if (ready && in_range && !is_zero) begin
      data = hit ? wr_data : mem[addr];
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parameterised multi-read register file with a one-entry-per-cycle clear
// sequencer. Define REGFILE_PARAM_BYPASS_EN for write-through read forwarding.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = clog2(DEPTH)
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [NREAD*AW-1:0]    ReadRegister,
  output logic [NREAD*WIDTH-1:0] ReadData,
  input  logic [AW-1:0]          WriteRegister,
  input  logic [WIDTH-1:0]       WriteData,
  input  logic                   RegWrite,
  input  logic                   Clear,
  output logic                   Ready
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t                      state;
  logic [AW-1:0]               clr_ptr;
  logic                        ready;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        wr_legal;
  logic                        wr_fwd;

  assign wr_legal = RegWrite
                 && ({1'b0, WriteRegister} < DEPTH_W)
                 && !((ZERO_REG != 0) && (WriteRegister == '0));

  // A Clear in RUN wins over a same-cycle write.
  assign wr_fwd = (state == ST_RUN) && !Clear && wr_legal;

  assign Ready = ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_INIT;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (Clear) begin
            clr_ptr <= '0;
          end else if (clr_ptr == LAST) begin
            state   <= ST_RUN;
            ready   <= 1'b1;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + AW'(1);
          end
        end
        ST_RUN: begin
          if (Clear) begin
            state   <= ST_INIT;
            ready   <= 1'b0;
            clr_ptr <= '0;
          end
        end
        default: begin
          state   <= ST_INIT;
          ready   <= 1'b0;
          clr_ptr <= '0;
        end
      endcase
    end
  end

  // The array has no reset; the INIT sweep is what zeroes it.
  always_ff @(posedge Clk) begin
    if (state == ST_INIT) begin
      mem[clr_ptr] <= '0;
    end else if (wr_fwd) begin
      mem[WriteRegister] <= WriteData;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    regfile_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
    ) u_rd (
      .mem     (mem),
      .ready   (ready),
      .addr    (ReadRegister[i*AW +: AW]),
      .wr_fwd  (wr_fwd),
      .wr_addr (WriteRegister),
      .wr_data (WriteData),
      .data    (ReadData[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations share one stimulus stream and
// are compared against a countdown/array reference model.
module tb_regfile_param;

  localparam int DEP [3] = '{32, 32, 20};
  localparam bit ZR  [3] = '{1'b1, 1'b0, 1'b1};

  logic         clk = 1'b0;
  logic         rst_n, clear, reg_write;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [19:0]  ra4;
  logic [9:0]   ra2;
  logic [127:0] rd_a;
  logic [63:0]  rd_b, rd_c;
  logic         rdy_a, rdy_b, rdy_c;

  int          vectors = 0;
  int          miscompares = 0;
  int          busy [3];
  logic [31:0] mem_m [3][32];

  always #5 clk = ~clk;

  regfile_param #(.WIDTH(32), .DEPTH(32), .NREAD(4), .ZERO_REG(1)) dut_a (
    .Clk(clk), .Reset_n(rst_n), .ReadRegister(ra4), .ReadData(rd_a),
    .WriteRegister(wr_addr), .WriteData(wr_data), .RegWrite(reg_write),
    .Clear(clear), .Ready(rdy_a));

  regfile_param #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(0)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .ReadRegister(ra2), .ReadData(rd_b),
    .WriteRegister(wr_addr), .WriteData(wr_data), .RegWrite(reg_write),
    .Clear(clear), .Ready(rdy_b));

  regfile_param #(.WIDTH(32), .DEPTH(20), .NREAD(2), .ZERO_REG(1)) dut_c (
    .Clk(clk), .Reset_n(rst_n), .ReadRegister(ra2), .ReadData(rd_c),
    .WriteRegister(wr_addr), .WriteData(wr_data), .RegWrite(reg_write),
    .Clear(clear), .Ready(rdy_c));

  // ---------------- reference model ----------------
  function automatic bit wr_ok(int k);
    return reg_write && (int'(wr_addr) < DEP[k]) && !(ZR[k] && wr_addr == 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
    if (busy[k] != 0 || int'(a) >= DEP[k] || (ZR[k] && a == 5'd0)) return 32'd0;
`ifdef REGFILE_PARAM_BYPASS_EN
    if (wr_ok(k) && !clear && a == wr_addr) return wr_data;
`endif
    return mem_m[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      busy[k] = DEP[k];
      for (int i = 0; i < 32; i++) mem_m[k][i] = 32'd0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n || clear) begin
        busy[k] = DEP[k];
        for (int i = 0; i < 32; i++) mem_m[k][i] = 32'd0;
      end else if (busy[k] > 0) begin
        busy[k]--;
      end else if (wr_ok(k)) begin
        mem_m[k][wr_addr] = wr_data;
      end
    end
  endtask

  // DUT accessors for loops over configurations
  function automatic int nports(int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic logic [4:0] ra_of(int k, int p);
    return (k == 0) ? ra4[p*5 +: 5] : ra2[p*5 +: 5];
  endfunction

  function automatic logic [31:0] rd_of(int k, int p);
    case (k)
      0:       return rd_a[p*32 +: 32];
      1:       return rd_b[p*32 +: 32];
      default: return rd_c[p*32 +: 32];
    endcase
  endfunction

  function automatic logic rdy_of(int k);
    case (k)
      0:       return rdy_a;
      1:       return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs(bit allow_clear);
    clear     = allow_clear && ($urandom_range(0, 149) == 0);
    reg_write = 1'($urandom_range(0, 1));
    wr_addr   = 5'($urandom);
    wr_data   = $urandom;
    ra4       = 20'($urandom);
    ra2       = 10'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      ra4[4:0] = wr_addr;
      ra2[4:0] = wr_addr;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int low_a, low_c;
    rst_n = 1'b0; clear = 1'b0; reg_write = 1'b0;
    wr_addr = '0; wr_data = '0; ra4 = '0; ra2 = '0;
    model_reset();
    repeat (3) tick();
    #1;
    vectors++;
    if ({rdy_a, rdy_b, rdy_c} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 000", {rdy_a, rdy_b, rdy_c});
    end
    rst_n = 1'b1;
    low_a = 0; low_c = 0;
    for (int c = 0; c < 40 && rdy_a !== 1'b1; c++) begin
      reg_write = 1'b1; wr_addr = 5'd5; wr_data = $urandom;
      for (int p = 0; p < 4; p++) ra4[p*5 +: 5] = 5'((c + 8*p) % 32);
      ra2 = 10'($urandom);
      #1;
      if (rdy_c !== 1'b1) low_c++;
      low_a++;
      for (int p = 0; p < 4; p++) begin
        vectors++;
        if (rd_a[p*32 +: 32] !== 32'd0) begin
          miscompares++;
          $display("FAIL init_read port%0d addr %0d: got %h want 0", p, ra4[p*5 +: 5], rd_a[p*32 +: 32]);
        end
      end
      tick();
    end
    reg_write = 1'b0; ra4 = {4{5'd5}}; ra2 = {2{5'd5}};
    #1;
    vectors++;
    if (low_a != 32) begin miscompares++; $display("FAIL init_len_a: got %0d want 32", low_a); end
    vectors++;
    if (low_c != 20) begin miscompares++; $display("FAIL init_len_c: got %0d want 20", low_c); end
    vectors++;
    if (rd_a[31:0] !== 32'd0) begin
      miscompares++; $display("FAIL init_write_dropped_a: got %h want 0", rd_a[31:0]);
    end
    vectors++;
    if (rd_b[31:0] !== 32'd0) begin
      miscompares++; $display("FAIL init_write_dropped_b: got %h want 0", rd_b[31:0]);
    end
    vectors++;
    if (rd_c[31:0] !== exp_rd(2, 5'd5)) begin
      miscompares++; $display("FAIL init_write_c: got %h want %h", rd_c[31:0], exp_rd(2, 5'd5));
    end
  endtask

  task automatic test_write_basic();
    logic [31:0] want [3] = '{32'd42, 32'd15, 32'd15};
    logic [31:0] dat  [3] = '{32'd42, 32'd15, 32'd99};
    bit          we   [3] = '{1'b1, 1'b1, 1'b0};
    ra4 = {4{5'd2}}; ra2 = {2{5'd2}};
    for (int s = 0; s < 3; s++) begin
      reg_write = we[s]; wr_addr = 5'd2; wr_data = dat[s];
      tick();
      reg_write = 1'b0;
      #1;
      for (int p = 0; p < 4; p++) begin
        vectors++;
        if (rd_a[p*32 +: 32] !== want[s]) begin
          miscompares++;
          $display("FAIL write_step%0d port%0d: got %0d want %0d", s, p, rd_a[p*32 +: 32], want[s]);
        end
      end
      vectors++;
      if (rd_b[63:32] !== want[s]) begin
        miscompares++; $display("FAIL write_step%0d_b: got %0d want %0d", s, rd_b[63:32], want[s]);
      end
    end
    reg_write = 1'b1; wr_addr = 5'd2; wr_data = 32'd25;
    tick();
    reg_write = 1'b0; ra4 = {5'd3, 5'd3, 5'd3, 5'd2};
    #1;
    vectors++;
    if (rd_a[31:0] !== 32'd25) begin
      miscompares++; $display("FAIL isolate_p0: got %0d want 25", rd_a[31:0]);
    end
    vectors++;
    if (rd_a[63:32] === 32'd25 || rd_a[63:32] !== exp_rd(0, 5'd3)) begin
      miscompares++; $display("FAIL isolate_p1: got %0d want %0d (not 25)", rd_a[63:32], exp_rd(0, 5'd3));
    end
  endtask

  task automatic test_sweep();
    logic [31:0] vals [32];
    logic [31:0] want;
    vals[0] = 32'd0;
    for (int a = 1; a < 32; a++) begin
      vals[a] = {8'(a), 24'($urandom)};
      reg_write = 1'b1; wr_addr = 5'(a); wr_data = vals[a];
      tick();
    end
    reg_write = 1'b0;
    for (int a = 0; a < 32; a++) begin
      for (int p = 0; p < 4; p++) ra4[p*5 +: 5] = 5'(a);
      ra2 = {5'(31 - a), 5'(a)};
      #1;
      want = (a == 0) ? 32'd0 : vals[a];
      for (int p = 0; p < 4; p++) begin
        vectors++;
        if (rd_a[p*32 +: 32] !== want) begin
          miscompares++;
          $display("FAIL sweep_a addr %0d port%0d: got %h want %h", a, p, rd_a[p*32 +: 32], want);
        end
      end
      for (int k = 1; k < 3; k++) begin
        for (int p = 0; p < 2; p++) begin
          vectors++;
          if (rd_of(k, p) !== exp_rd(k, ra_of(k, p))) begin
            miscompares++;
            $display("FAIL sweep dut%0d port%0d addr %0d: got %h want %h", k, p, ra_of(k, p), rd_of(k, p), exp_rd(k, ra_of(k, p)));
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_zero_reg();
    reg_write = 1'b1; wr_addr = 5'd0; wr_data = 32'd30;
    tick();
    reg_write = 1'b0; ra4 = '0; ra2 = '0;
    #1;
    vectors++;
    if (rd_a !== 128'd0) begin miscompares++; $display("FAIL zero_reg_a: got %h want 0", rd_a); end
    vectors++;
    if (rd_b[31:0] !== 32'd30) begin miscompares++; $display("FAIL zero_reg_b: got %0d want 30", rd_b[31:0]); end
    vectors++;
    if (rd_c[31:0] !== 32'd0) begin miscompares++; $display("FAIL zero_reg_c: got %0d want 0", rd_c[31:0]); end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    reg_write = 1'b1; wr_addr = 5'd3; wr_data = 32'd7;
    tick();
    wr_data = 32'd35; ra4 = {4{5'd3}}; ra2 = {2{5'd3}};
    #1;
`ifdef REGFILE_PARAM_BYPASS_EN
    want = 32'd35;
`else
    want = 32'd7;
`endif
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < nports(k); p++) begin
        vectors++;
        if (rd_of(k, p) !== want) begin
          miscompares++;
          $display("FAIL same_cycle dut%0d port%0d: got %0d want %0d", k, p, rd_of(k, p), want);
        end
      end
    end
    tick();
    reg_write = 1'b0;
    #1;
    vectors++;
    if (rd_a[31:0] !== 32'd35) begin miscompares++; $display("FAIL after_edge: got %0d want 35", rd_a[31:0]); end
    // zero register never forwards
    reg_write = 1'b1; wr_addr = 5'd0; wr_data = 32'd55; ra4 = '0; ra2 = '0;
    #1;
    vectors++;
    if (rd_a[31:0] !== 32'd0) begin miscompares++; $display("FAIL zero_fwd_a: got %0d want 0", rd_a[31:0]); end
    vectors++;
    if (rd_b[31:0] !== exp_rd(1, 5'd0)) begin
      miscompares++; $display("FAIL zero_fwd_b: got %0d want %0d", rd_b[31:0], exp_rd(1, 5'd0));
    end
    tick();
    // address 25 is out of range for the 20-entry instance only
    reg_write = 1'b1; wr_addr = 5'd25; wr_data = 32'd77; ra2 = {5'd5, 5'd25};
    #1;
    vectors++;
    if (rd_c[31:0] !== 32'd0) begin miscompares++; $display("FAIL oor_fwd_c: got %0d want 0", rd_c[31:0]); end
    tick();
    reg_write = 1'b0;
    #1;
    vectors++;
    if (rd_c[31:0] !== 32'd0) begin miscompares++; $display("FAIL oor_read_c: got %0d want 0", rd_c[31:0]); end
    vectors++;
    if (rd_c[63:32] !== exp_rd(2, 5'd5)) begin
      miscompares++; $display("FAIL oor_alias_c: got %0d want %0d", rd_c[63:32], exp_rd(2, 5'd5));
    end
    vectors++;
    if (rd_b[31:0] !== 32'd77) begin miscompares++; $display("FAIL inrange_b: got %0d want 77", rd_b[31:0]); end
  endtask

  task automatic test_clear();
    int n;
    for (int a = 1; a < 32; a++) begin
      reg_write = 1'b1; wr_addr = 5'(a); wr_data = 32'(a);
      tick();
    end
    clear = 1'b1; reg_write = 1'b1; wr_addr = 5'd1; wr_data = 32'hdead;
    tick();
    clear = 1'b0; reg_write = 1'b0;
    #1;
    vectors++;
    if (rdy_a !== 1'b0) begin miscompares++; $display("FAIL clear_drop: got %b want 0", rdy_a); end
    for (int c = 0; c < 10; c++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    while (rdy_a !== 1'b1 && n < 50) begin
      ra4 = 20'($urandom);
      #1;
      vectors++;
      if (rd_a !== 128'd0) begin miscompares++; $display("FAIL clear_busy_read: got %h want 0", rd_a); end
      n++;
      tick();
    end
    vectors++;
    if (n != 32) begin miscompares++; $display("FAIL clear_restart_len: got %0d want 32", n); end
    for (int a = 0; a < 32; a++) begin
      ra4 = {5'(a), 5'(31 - a), 5'(a), 5'(a)};
      ra2 = {5'(a), 5'(a)};
      #1;
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < nports(k); p++) begin
          vectors++;
          if (rd_of(k, p) !== 32'd0) begin
            miscompares++;
            $display("FAIL cleared dut%0d port%0d addr %0d: got %h want 0", k, p, ra_of(k, p), rd_of(k, p));
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_inputs(1'b1);
      #1;
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (rdy_of(k) !== (busy[k] == 0)) begin
          miscompares++; $display("FAIL rand_ready dut%0d cyc %0d: got %b want %b", k, c, rdy_of(k), busy[k] == 0);
        end
        for (int p = 0; p < nports(k); p++) begin
          vectors++;
          if (rd_of(k, p) !== exp_rd(k, ra_of(k, p))) begin
            miscompares++;
            $display("FAIL rand_read dut%0d port%0d addr %0d cyc %0d: got %h want %h", k, p, ra_of(k, p), c, rd_of(k, p), exp_rd(k, ra_of(k, p)));
          end
        end
      end
      tick();
    end
    clear = 1'b0;
  endtask

  task automatic test_reset_mid();
    rand_inputs(1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({rdy_a, rdy_b, rdy_c} !== 3'b000) begin
      miscompares++; $display("FAIL midreset_ready: got %b want 000", {rdy_a, rdy_b, rdy_c});
    end
    vectors++;
    if (rd_a !== 128'd0 || rd_b !== 64'd0 || rd_c !== 64'd0) begin
      miscompares++; $display("FAIL midreset_read: got %h/%h/%h want 0", rd_a, rd_b, rd_c);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 45; c++) begin
      rand_inputs(1'b0);
      #1;
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (rdy_of(k) !== (busy[k] == 0)) begin
          miscompares++; $display("FAIL post_reset_ready dut%0d cyc %0d: got %b want %b", k, c, rdy_of(k), busy[k] == 0);
        end
        for (int p = 0; p < nports(k); p++) begin
          vectors++;
          if (rd_of(k, p) !== exp_rd(k, ra_of(k, p))) begin
            miscompares++;
            $display("FAIL post_reset_read dut%0d port%0d cyc %0d: got %h want %h", k, p, c, rd_of(k, p), exp_rd(k, ra_of(k, p)));
          end
        end
      end
      tick();
    end
    reg_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_sweep();
    test_zero_reg();
    test_bypass();
    test_clear();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
    $fatal(1);
  end

endmodule
